decode_ctrl_pipe: RTL and testbench

Registered decode/control stage for the pipelined RV32 core, sitting between the IF/ID register and the execute stage. It decodes RV32I, plus RV32M when enabled, into a registered control bundle. It detects load-use hazards and inserts bubbles, sequences multi-cycle MUL/DIV occupancy, and honours branch/jump flushes and downstream back-pressure through a valid/ready handshake.

---
 rtl/riscv_ctrl_pkg.sv | 74 +++++++
 rtl/decode_ctrl_pipe_decode.sv | 148 ++++++++++++++
 rtl/decode_ctrl_pipe.sv | 111 +++++++++++
 tb/tb_decode_ctrl_pipe.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared decode definitions for the RV32 decode/control stage: opcodes, ALU op codes,
// write-back selects and the registered control bundle.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // Bit positions inside the one-hot instruction type vector
    localparam int TYPE_W = 9;
    localparam int T_I     = 0;
    localparam int T_LUI   = 1;
    localparam int T_AUIPC = 2;
    localparam int T_R     = 3;
    localparam int T_S     = 4;
    localparam int T_LD    = 5;
    localparam int T_B     = 6;
    localparam int T_JAL   = 7;
    localparam int T_JALR  = 8;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_MUL    = 5'd10,
        ALU_MULH   = 5'd11,
        ALU_MULHSU = 5'd12,
        ALU_MULHU  = 5'd13,
        ALU_DIV    = 5'd14,
        ALU_DIVU   = 5'd15,
        ALU_REM    = 5'd16,
        ALU_REMU   = 5'd17,
        ALU_PASSB  = 5'd18
    } aluop_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_PC4 = 2'b01,
        WB_MEM = 2'b10
    } wb_sel_e;

    typedef struct packed {
        logic              valid;
        aluop_e            aluop;
        logic [TYPE_W-1:0] typ;
        logic              rf_en;
        logic              rd_en;
        logic              wr_en;
        wb_sel_e           wb_sel;
        logic [2:0]        br_type;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic              illegal;
    } ctrl_t;

endpackage

// File: rtl/decode_ctrl_pipe_decode.sv
// Combinational RV32I(+M) decoder: instruction word to control bundle.
// Anything not explicitly recognised comes out as a clean illegal bundle.
module rv_decode
    import riscv_ctrl_pkg::*;
#(
    parameter int M_EXT = 1
) (
    input  logic        valid,
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic        is_md
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       bad;
    ctrl_t      c;
    logic       md;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    always_comb begin
        c         = '0;
        md        = 1'b0;
        bad       = 1'b0;
        c.valid   = valid;
        c.rs1     = instr[19:15];
        c.rs2     = instr[24:20];
        c.rd      = instr[11:7];
        case (opcode)
            OP_REG: begin
                c.typ[T_R] = 1'b1;
                c.rf_en    = 1'b1;
                if (f7 == F7_BASE) begin
                    case (f3)
                        3'b000: c.aluop = ALU_ADD;
                        3'b001: c.aluop = ALU_SLL;
                        3'b010: c.aluop = ALU_SLT;
                        3'b011: c.aluop = ALU_SLTU;
                        3'b100: c.aluop = ALU_XOR;
                        3'b101: c.aluop = ALU_SRL;
                        3'b110: c.aluop = ALU_OR;
                        3'b111: c.aluop = ALU_AND;
                    endcase
                end else if (f7 == F7_ALT) begin
                    case (f3)
                        3'b000:  c.aluop = ALU_SUB;
                        3'b101:  c.aluop = ALU_SRA;
                        default: bad = 1'b1;
                    endcase
                end else if (M_EXT != 0 && f7 == F7_MULDIV) begin
                    md = 1'b1;
                    case (f3)
                        3'b000: c.aluop = ALU_MUL;
                        3'b001: c.aluop = ALU_MULH;
                        3'b010: c.aluop = ALU_MULHSU;
                        3'b011: c.aluop = ALU_MULHU;
                        3'b100: c.aluop = ALU_DIV;
                        3'b101: c.aluop = ALU_DIVU;
                        3'b110: c.aluop = ALU_REM;
                        3'b111: c.aluop = ALU_REMU;
                    endcase
                end else begin
                    bad = 1'b1;
                end
            end
            OP_IMM: begin
                c.typ[T_I] = 1'b1;
                c.rf_en    = 1'b1;
                case (f3)
                    3'b000: c.aluop = ALU_ADD;
                    3'b001: begin
                        c.aluop = ALU_SLL;
                        bad     = (f7 != F7_BASE);
                    end
                    3'b010: c.aluop = ALU_SLT;
                    3'b011: c.aluop = ALU_SLTU;
                    3'b100: c.aluop = ALU_XOR;
                    3'b101: begin
                        // Shift-right immediates carry their variant in the upper immediate bits
                        if (f7 == F7_BASE)     c.aluop = ALU_SRL;
                        else if (f7 == F7_ALT) c.aluop = ALU_SRA;
                        else                   bad = 1'b1;
                    end
                    3'b110: c.aluop = ALU_OR;
                    3'b111: c.aluop = ALU_AND;
                endcase
            end
            OP_LOAD: begin
                c.typ[T_LD] = 1'b1;
                c.rf_en     = 1'b1;
                c.rd_en     = 1'b1;
                c.wb_sel    = WB_MEM;
                bad         = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OP_STORE: begin
                c.typ[T_S] = 1'b1;
                c.wr_en    = 1'b1;
                bad        = (f3 > 3'b010);
            end
            OP_BRANCH: begin
                c.typ[T_B] = 1'b1;
                c.br_type  = f3;
                bad        = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OP_LUI: begin
                c.typ[T_LUI] = 1'b1;
                c.rf_en      = 1'b1;
                c.aluop      = ALU_PASSB;
            end
            OP_AUIPC: begin
                c.typ[T_AUIPC] = 1'b1;
                c.rf_en        = 1'b1;
            end
            OP_JAL: begin
                c.typ[T_JAL] = 1'b1;
                c.rf_en      = 1'b1;
                c.wb_sel     = WB_PC4;
            end
            OP_JALR: begin
                c.typ[T_JALR] = 1'b1;
                c.rf_en       = 1'b1;
                c.wb_sel      = WB_PC4;
                bad           = (f3 != 3'b000);
            end
            default: bad = 1'b1;
        endcase

        if (bad) begin
            c.aluop   = ALU_ADD;
            c.typ     = '0;
            c.rf_en   = 1'b0;
            c.rd_en   = 1'b0;
            c.wr_en   = 1'b0;
            c.wb_sel  = WB_ALU;
            c.br_type = 3'b000;
            c.illegal = 1'b1;
            md        = 1'b0;
        end
    end

    assign ctrl  = c;
    assign is_md = md;

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Registered decode/control stage: decodes IF/ID, inserts load-use and M-op bubbles,
// and honours flush and execute back-pressure.
module decode_ctrl_pipe
    import riscv_ctrl_pkg::*;
#(
    parameter int M_EXT   = 1,
    parameter int MD_LAT  = 4,
    parameter int ALUOP_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               if_valid,
    input  logic [31:0]        if_instr,
    output logic               id_ready,
    input  logic               ex_ready,
    input  logic               flush,
    output logic               ex_valid,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic [8:0]         ex_type,
    output logic               ex_rf_en,
    output logic               ex_rd_en,
    output logic               ex_wr_en,
    output logic [1:0]         ex_wb_sel,
    output logic [2:0]         ex_br_type,
    output logic [4:0]         ex_rs1,
    output logic [4:0]         ex_rs2,
    output logic [4:0]         ex_rd,
    output logic               ex_illegal,
    output logic               md_busy
);

    // MD_LAT=1 loads zero into the counter, so an M op then costs no bubbles
    localparam int              CNT_W   = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_LAT - 1);

    ctrl_t            dec;
    logic             dec_is_md;
    ctrl_t            ctrl_reg;
    ctrl_t            ctrl_next;
    logic [CNT_W-1:0] md_cnt_reg;
    logic [CNT_W-1:0] md_cnt_next;
    logic             load_in_ex;
    logic             use_rs1;
    logic             use_rs2;
    logic             hazard;
    logic             md_stall;
    logic             stall;

    rv_decode #(.M_EXT(M_EXT)) u_decode (
        .valid (if_valid),
        .instr (if_instr),
        .ctrl  (dec),
        .is_md (dec_is_md)
    );

    assign load_in_ex = ctrl_reg.valid & ctrl_reg.rd_en & (ctrl_reg.rd != 5'd0);
    assign use_rs1    = dec.typ[T_I] | dec.typ[T_LD] | dec.typ[T_S] | dec.typ[T_B]
                      | dec.typ[T_R] | dec.typ[T_JALR];
    assign use_rs2    = dec.typ[T_S] | dec.typ[T_B] | dec.typ[T_R];
    assign hazard     = if_valid & load_in_ex
                      & ((use_rs1 & (dec.rs1 == ctrl_reg.rd)) | (use_rs2 & (dec.rs2 == ctrl_reg.rd)));
    assign md_stall   = (md_cnt_reg != '0);
    assign stall      = hazard | md_stall;
    assign id_ready   = ex_ready & ~hazard & ~md_stall & rst_n;

    always_comb begin
        ctrl_next   = ctrl_reg;
        md_cnt_next = md_cnt_reg;
        if (flush) begin
            ctrl_next   = '0;
            md_cnt_next = '0;
        end else if (!ex_ready) begin
            ctrl_next   = ctrl_reg;
        end else if (stall) begin
            ctrl_next = '0;
            if (md_stall) begin
                md_cnt_next = md_cnt_reg - CNT_W'(1);
            end
        end else begin
            ctrl_next = dec;
            if (if_valid && dec_is_md) begin
                md_cnt_next = MD_LOAD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_reg   <= '0;
            md_cnt_reg <= '0;
        end else begin
            ctrl_reg   <= ctrl_next;
            md_cnt_reg <= md_cnt_next;
        end
    end

    assign ex_valid   = ctrl_reg.valid;
    assign ex_aluop   = ALUOP_W'(ctrl_reg.aluop);
    assign ex_type    = ctrl_reg.typ;
    assign ex_rf_en   = ctrl_reg.rf_en;
    assign ex_rd_en   = ctrl_reg.rd_en;
    assign ex_wr_en   = ctrl_reg.wr_en;
    assign ex_wb_sel  = ctrl_reg.wb_sel;
    assign ex_br_type = ctrl_reg.br_type;
    assign ex_rs1     = ctrl_reg.rs1;
    assign ex_rs2     = ctrl_reg.rs2;
    assign ex_rd      = ctrl_reg.rd;
    assign ex_illegal = ctrl_reg.illegal;
    assign md_busy    = md_stall;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Self-checking bench for decode_ctrl_pipe: directed vector table, multi-cycle
// sequences, and randomized traffic against a behavioural model.
module tb_decode_ctrl_pipe;

    localparam int MD_LAT = 4;

    typedef struct {
        bit ill;
        int alu;
        int typ;
        bit rf;
        bit rde;
        bit wre;
        int wb;
        int br;
        bit is_m;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_instr;
    logic        ex_ready;
    logic        flush;

    logic       id_ready, ex_valid, ex_rf_en, ex_rd_en, ex_wr_en, ex_illegal, md_busy;
    logic [4:0] ex_aluop, ex_rs1, ex_rs2, ex_rd;
    logic [8:0] ex_type;
    logic [1:0] ex_wb_sel;
    logic [2:0] ex_br_type;

    logic       z_id_ready, z_ex_valid, z_ex_rf_en, z_ex_rd_en, z_ex_wr_en, z_ex_illegal, z_md_busy;
    logic [4:0] z_ex_aluop, z_ex_rs1, z_ex_rs2, z_ex_rd;
    logic [8:0] z_ex_type;
    logic [1:0] z_ex_wb_sel;
    logic [2:0] z_ex_br_type;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    decode_ctrl_pipe #(.M_EXT(1), .MD_LAT(MD_LAT), .ALUOP_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr),
        .id_ready(id_ready), .ex_ready(ex_ready), .flush(flush), .ex_valid(ex_valid),
        .ex_aluop(ex_aluop), .ex_type(ex_type), .ex_rf_en(ex_rf_en), .ex_rd_en(ex_rd_en),
        .ex_wr_en(ex_wr_en), .ex_wb_sel(ex_wb_sel), .ex_br_type(ex_br_type),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_illegal(ex_illegal),
        .md_busy(md_busy)
    );

    decode_ctrl_pipe #(.M_EXT(0), .MD_LAT(1), .ALUOP_W(5)) dut_nom (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr),
        .id_ready(z_id_ready), .ex_ready(ex_ready), .flush(flush), .ex_valid(z_ex_valid),
        .ex_aluop(z_ex_aluop), .ex_type(z_ex_type), .ex_rf_en(z_ex_rf_en), .ex_rd_en(z_ex_rd_en),
        .ex_wr_en(z_ex_wr_en), .ex_wb_sel(z_ex_wb_sel), .ex_br_type(z_ex_br_type),
        .ex_rs1(z_ex_rs1), .ex_rs2(z_ex_rs2), .ex_rd(z_ex_rd), .ex_illegal(z_ex_illegal),
        .md_busy(z_md_busy)
    );

    function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    // Reference decode written from the instruction-set tables
    function automatic exp_t ref_decode(input logic [31:0] ins, input bit m_ext);
        exp_t       e;
        int         base_alu [8];
        logic [6:0] op;
        logic [6:0] f7;
        int         f3;
        bit         bad;
        base_alu = '{0, 2, 3, 4, 5, 6, 8, 9};
        op  = ins[6:0];
        f7  = ins[31:25];
        f3  = int'(ins[14:12]);
        e   = '{default: 0};
        bad = 1'b0;
        case (op)
            7'h33: begin
                e.typ = 8; e.rf = 1;
                if (f7 == 7'h00)                 e.alu = base_alu[f3];
                else if (f7 == 7'h20 && f3 == 0) e.alu = 1;
                else if (f7 == 7'h20 && f3 == 5) e.alu = 7;
                else if (f7 == 7'h01 && m_ext) begin e.alu = 10 + f3; e.is_m = 1; end
                else bad = 1;
            end
            7'h13: begin
                e.typ = 1; e.rf = 1; e.alu = base_alu[f3];
                if (f3 == 1 && f7 != 7'h00) bad = 1;
                if (f3 == 5 && f7 == 7'h20) e.alu = 7;
                else if (f3 == 5 && f7 != 7'h00) bad = 1;
            end
            7'h03: begin e.typ = 32; e.rf = 1; e.rde = 1; e.wb = 2; bad = (f3 == 3 || f3 >= 6); end
            7'h23: begin e.typ = 16; e.wre = 1; bad = (f3 > 2); end
            7'h63: begin e.typ = 64; e.br = f3; bad = (f3 == 2 || f3 == 3); end
            7'h37: begin e.typ = 2; e.rf = 1; e.alu = 18; end
            7'h17: begin e.typ = 4; e.rf = 1; end
            7'h6f: begin e.typ = 128; e.rf = 1; e.wb = 1; end
            7'h67: begin e.typ = 256; e.rf = 1; e.wb = 1; bad = (f3 != 0); end
            default: bad = 1;
        endcase
        if (bad) begin
            e     = '{default: 0};
            e.ill = 1;
        end
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [6:0] ops [9];
        logic [6:0] f7s [4];
        logic [6:0] f7;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h67};
        f7s = '{7'h00, 7'h20, 7'h01, 7'h00};
        if ($urandom_range(0, 9) == 0) return $urandom;
        f7 = ($urandom_range(0, 7) == 0) ? 7'($urandom) : f7s[$urandom_range(0, 3)];
        return {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom),
                5'($urandom_range(0, 3)), ops[$urandom_range(0, 8)]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cmp_exp(input string tag, input exp_t e);
        check({tag, ".illegal"}, 32'(ex_illegal), 32'(e.ill));
        check({tag, ".aluop"},   32'(ex_aluop),   32'(e.alu));
        check({tag, ".type"},    32'(ex_type),    32'(e.typ));
        check({tag, ".rf_en"},   32'(ex_rf_en),   32'(e.rf));
        check({tag, ".rd_en"},   32'(ex_rd_en),   32'(e.rde));
        check({tag, ".wr_en"},   32'(ex_wr_en),   32'(e.wre));
        check({tag, ".wb_sel"},  32'(ex_wb_sel),  32'(e.wb));
        check({tag, ".br_type"}, 32'(ex_br_type), 32'(e.br));
    endtask

    // Present an instruction until it is accepted; returns #1 after the accepting edge
    task automatic send(input logic [31:0] ins, output bit ok);
        if_instr = ins;
        if_valid = 1'b1;
        ok       = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (id_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        if_valid = 1'b0;
    endtask

    task automatic run_until_valid(output int edges, output int busy);
        edges = 0;
        busy  = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
            if (md_busy) busy++;
        end while (!ex_valid && edges < 20);
    endtask

    function automatic bit reads_rs1(input int t);
        return (t == 1) || (t == 32) || (t == 16) || (t == 64) || (t == 8) || (t == 256);
    endfunction

    function automatic bit reads_rs2(input int t);
        return (t == 16) || (t == 64) || (t == 8);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vt [20];
        bit          ok;
        int          edges, busy;
        logic [31:0] add_i, addi_i;
        exp_t        m_e, ne;
        logic [31:0] m_ins;
        bit          m_valid, hz, exp_rdy, pending;
        int          md_left;

        add_i  = r_t(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33);
        addi_i = i_t(12'd1, 5'd0, 3'd0, 5'd10, 7'h13);

        vt[0]  = '{add_i,                                        '{0, 0, 8, 1, 0, 0, 0, 0, 0}};
        vt[1]  = '{r_t(7'h20, 5'd2, 5'd1, 3'd0, 5'd4, 7'h33),    '{0, 1, 8, 1, 0, 0, 0, 0, 0}};
        vt[2]  = '{r_t(7'h20, 5'd2, 5'd1, 3'd5, 5'd4, 7'h33),    '{0, 7, 8, 1, 0, 0, 0, 0, 0}};
        vt[3]  = '{r_t(7'h00, 5'd2, 5'd1, 3'd3, 5'd4, 7'h33),    '{0, 4, 8, 1, 0, 0, 0, 0, 0}};
        vt[4]  = '{i_t(12'h003, 5'd2, 3'd1, 5'd1, 7'h13),        '{0, 2, 1, 1, 0, 0, 0, 0, 0}};
        vt[5]  = '{i_t(12'h403, 5'd2, 3'd5, 5'd1, 7'h13),        '{0, 7, 1, 1, 0, 0, 0, 0, 0}};
        vt[6]  = '{i_t(12'h023, 5'd2, 3'd5, 5'd1, 7'h13),        '{1, 0, 0, 0, 0, 0, 0, 0, 0}};
        vt[7]  = '{i_t(12'd4, 5'd1, 3'd2, 5'd5, 7'h03),          '{0, 0, 32, 1, 1, 0, 2, 0, 0}};
        vt[8]  = '{r_t(7'h00, 5'd2, 5'd1, 3'd2, 5'd8, 7'h23),    '{0, 0, 16, 0, 0, 1, 0, 0, 0}};
        vt[9]  = '{r_t(7'h00, 5'd2, 5'd1, 3'd4, 5'd0, 7'h63),    '{0, 0, 64, 0, 0, 0, 0, 4, 0}};
        vt[10] = '{r_t(7'h00, 5'd2, 5'd1, 3'd2, 5'd0, 7'h63),    '{1, 0, 0, 0, 0, 0, 0, 0, 0}};
        vt[11] = '{{20'h12345, 5'd7, 7'h37},                     '{0, 18, 2, 1, 0, 0, 0, 0, 0}};
        vt[12] = '{{20'h00010, 5'd7, 7'h17},                     '{0, 0, 4, 1, 0, 0, 0, 0, 0}};
        vt[13] = '{{20'h00100, 5'd1, 7'h6f},                     '{0, 0, 128, 1, 0, 0, 1, 0, 0}};
        vt[14] = '{i_t(12'd0, 5'd2, 3'd0, 5'd1, 7'h67),          '{0, 0, 256, 1, 0, 0, 1, 0, 0}};
        vt[15] = '{i_t(12'd0, 5'd2, 3'd1, 5'd1, 7'h67),          '{1, 0, 0, 0, 0, 0, 0, 0, 0}};
        vt[16] = '{32'h0000_0000,                                '{1, 0, 0, 0, 0, 0, 0, 0, 0}};
        vt[17] = '{r_t(7'h01, 5'd2, 5'd1, 3'd6, 5'd3, 7'h33),    '{0, 16, 8, 1, 0, 0, 0, 0, 1}};
        vt[18] = '{r_t(7'h01, 5'd2, 5'd1, 3'd2, 5'd3, 7'h33),    '{0, 12, 8, 1, 0, 0, 0, 0, 1}};
        vt[19] = '{r_t(7'h20, 5'd2, 5'd1, 3'd1, 5'd3, 7'h33),    '{1, 0, 0, 0, 0, 0, 0, 0, 0}};

        // Reset with a valid instruction waiting
        rst_n = 1'b0; if_valid = 1'b1; if_instr = add_i; ex_ready = 1'b1; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.ex_valid", 32'(ex_valid), 0);
        check("rst.aluop",    32'(ex_aluop), 0);
        check("rst.type",     32'(ex_type),  0);
        check("rst.rf_en",    32'(ex_rf_en), 0);
        check("rst.rd",       32'(ex_rd),    0);
        check("rst.illegal",  32'(ex_illegal), 0);
        check("rst.md_busy",  32'(md_busy),  0);
        check("rst.id_ready", 32'(id_ready), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        if_valid = 1'b0;
        check("rel.ex_valid", 32'(ex_valid), 1);
        cmp_exp("rel", vt[0].e);
        $display("[TB] reset release: add issued");

        // div with M enabled vs disabled, then occupancy bubbles
        send(r_t(7'h01, 5'd9, 5'd8, 3'd4, 5'd7, 7'h33), ok);
        check("div.accept",     32'(ok), 1);
        check("div.aluop",      32'(ex_aluop), 14);
        check("div.md_busy",    32'(md_busy), 1);
        check("div.id_ready",   32'(id_ready), 0);
        check("nom.illegal",    32'(z_ex_illegal), 1);
        check("nom.rf_en",      32'(z_ex_rf_en), 0);
        check("nom.type",       32'(z_ex_type), 0);
        check("nom.md_busy",    32'(z_md_busy), 0);
        if_instr = addi_i; if_valid = 1'b1;
        run_until_valid(edges, busy);
        if_valid = 1'b0;
        check("mop.edges",      32'(edges), 4);
        check("mop.busy",       32'(busy + 1), 3);
        check("mop.addi_type",  32'(ex_type), 1);
        $display("[TB] div then addi: addi after %0d cycles", edges);

        // Flush on the second M-op stall cycle
        send(r_t(7'h01, 5'd9, 5'd8, 3'd0, 5'd7, 7'h33), ok);
        check("mflush.accept",  32'(ok), 1);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("mflush.ex_valid", 32'(ex_valid), 0);
        check("mflush.md_busy",  32'(md_busy), 0);
        check("mflush.id_ready", 32'(id_ready), 1);
        $display("[TB] flush mid M-op");

        // Load-use, then the same with rd=x0
        send(i_t(12'd0, 5'd1, 3'd2, 5'd5, 7'h03), ok);
        if_instr = r_t(7'h00, 5'd2, 5'd5, 3'd0, 5'd6, 7'h33); if_valid = 1'b1;
        #1;
        check("lu.id_ready", 32'(id_ready), 0);
        run_until_valid(edges, busy);
        if_valid = 1'b0;
        check("lu.edges", 32'(edges), 2);
        check("lu.rd",    32'(ex_rd), 6);
        $display("[TB] load-use x5: add after %0d cycles", edges);
        send(i_t(12'd0, 5'd1, 3'd2, 5'd0, 7'h03), ok);
        if_instr = r_t(7'h00, 5'd2, 5'd0, 3'd0, 5'd6, 7'h33); if_valid = 1'b1;
        run_until_valid(edges, busy);
        if_valid = 1'b0;
        check("lu0.edges", 32'(edges), 1);
        $display("[TB] load-use x0: add after %0d cycles", edges);

        // Hazard while back-pressured: hold first, bubble only after release
        send(i_t(12'd0, 5'd1, 3'd2, 5'd5, 7'h03), ok);
        ex_ready = 1'b0;
        if_instr = r_t(7'h00, 5'd5, 5'd2, 3'd0, 5'd6, 7'h33); if_valid = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("luhold.ex_valid", 32'(ex_valid), 1);
            check("luhold.rd_en",    32'(ex_rd_en), 1);
        end
        ex_ready = 1'b1;
        run_until_valid(edges, busy);
        if_valid = 1'b0;
        check("luhold.edges", 32'(edges), 2);
        $display("[TB] load-use under back-pressure: add after %0d cycles", edges);

        // Back-pressure holding a jal
        send(vt[13].instr, ok);
        ex_ready = 1'b0;
        if_instr = i_t(12'd5, 5'd0, 3'd0, 5'd11, 7'h13); if_valid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("bp.ex_valid", 32'(ex_valid), 1);
            check("bp.type",     32'(ex_type), 128);
            check("bp.wb_sel",   32'(ex_wb_sel), 1);
            check("bp.id_ready", 32'(id_ready), 0);
        end
        ex_ready = 1'b1;
        @(posedge clk);
        #1;
        if_valid = 1'b0;
        check("bp.next_valid", 32'(ex_valid), 1);
        check("bp.next_rd",    32'(ex_rd), 11);
        $display("[TB] back-pressure on jal released");

        // Directed decode table
        for (int v = 0; v < 20; v++) begin
            send(vt[v].instr, ok);
            check($sformatf("vec%0d.accept", v), 32'(ok), 1);
            check($sformatf("vec%0d.ex_valid", v), 32'(ex_valid), 1);
            cmp_exp($sformatf("vec%0d", v), vt[v].e);
            $display("[TB] vec %0d instr=%08h aluop=%0d type=%03h illegal=%0d",
                     v, vt[v].instr, ex_aluop, ex_type, ex_illegal);
        end

        // Randomized traffic against the behavioural model
        rst_n = 1'b0; if_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        m_valid = 1'b0; m_e = '{default: 0}; m_ins = '0; md_left = 0; pending = 1'b0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            if (!pending) begin
                if_valid = ($urandom_range(0, 3) != 0);
                if_instr = gen_instr();
            end
            ex_ready = ($urandom_range(0, 4) != 0);
            flush    = ($urandom_range(0, 19) == 0);
            #1;
            ne = ref_decode(if_instr, 1'b1);
            hz = m_valid && m_e.rde && (m_ins[11:7] != 5'd0) && if_valid &&
                 ((reads_rs1(ne.typ) && if_instr[19:15] == m_ins[11:7]) ||
                  (reads_rs2(ne.typ) && if_instr[24:20] == m_ins[11:7]));
            exp_rdy = ex_ready && !hz && (md_left == 0);
            check("rnd.id_ready", 32'(id_ready), 32'(exp_rdy));
            check("rnd.ex_valid", 32'(ex_valid), 32'(m_valid));
            check("rnd.md_busy",  32'(md_busy),  32'(md_left != 0));
            if (m_valid) begin
                cmp_exp("rnd", m_e);
                if (!m_e.ill) begin
                    check("rnd.rs1", 32'(ex_rs1), 32'(m_ins[19:15]));
                    check("rnd.rs2", 32'(ex_rs2), 32'(m_ins[24:20]));
                    check("rnd.rd",  32'(ex_rd),  32'(m_ins[11:7]));
                end
            end
            pending = if_valid && !exp_rdy && !flush;
            if (flush) begin
                m_valid = 1'b0;
                md_left = 0;
            end else if (!ex_ready) begin
                m_valid = m_valid;
            end else if (hz || md_left > 0) begin
                m_valid = 1'b0;
                if (md_left > 0) md_left--;
            end else begin
                m_valid = if_valid;
                m_ins   = if_instr;
                m_e     = ne;
                if (if_valid && ne.is_m) md_left = MD_LAT - 1;
                if (if_valid) $display("[TB] rnd cycle %0d accept %08h", cyc, if_instr);
            end
        end
        flush = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
